ic_fetch_ctrl: RTL and testbench

- Core-side fetch engine; the initiator of the icache core interface.
- Generates sequential fetch PCs, issues them on coretoic_pc with valid/retry, and tracks in-flight requests with a credit counter.
- Collects in-order ictocore responses, pairs each with its PC, and buffers the pair for decode.
- Handles branch redirects by flushing queued data and dropping stale in-flight responses.

---
 rtl/ic_fetch_ctrl_pkg.sv | 20 ++
 rtl/ic_fetch_ctrl_if.sv | 46 ++++
 rtl/ic_fetch_fifo.sv | 65 ++++++
 rtl/ic_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_ic_fetch_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ic_fetch_ctrl_pkg.sv
// Shared constants and types for the core-side instruction fetch engine.
package ic_fetch_ctrl_pkg;

    localparam int IC_PC_W        = 50;
    localparam int IC_DATA_W      = 128;
    localparam int IC_FETCH_BYTES = 16;
    localparam int IC_MAX_OUTS    = 4;

    typedef struct packed {
        logic [IC_PC_W-1:0]   pc;
        logic [IC_DATA_W-1:0] data;
    } I_fetch_blk_type;

    // DRAIN while stale icache responses are still owed to us.
    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/ic_fetch_ctrl_if.sv
// Redirect, icache request/response and decode signals of the fetch engine.
// Optional statistics outputs exist only when FETCH_STATS_EN is defined.
interface ic_fetch_ctrl_if
    import ic_fetch_ctrl_pkg::*;
#(
    parameter int PC_W   = IC_PC_W,
    parameter int DATA_W = IC_DATA_W
);
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              coretoic_pc_valid;
    logic              coretoic_pc_retry;
    logic [PC_W-1:0]   coretoic_pc;
    logic              ictocore_valid;
    logic              ictocore_retry;
    logic [DATA_W-1:0] ictocore;
    logic              fetch_valid;
    logic              fetch_retry;
    logic [PC_W-1:0]   fetch_pc;
    logic [DATA_W-1:0] fetch_data;
`ifdef FETCH_STATS_EN
    logic [31:0]       stat_issued;
    logic [31:0]       stat_dropped;
    logic [31:0]       stat_stall;

    modport master (
        input  redirect_valid, redirect_pc, coretoic_pc_retry, ictocore_valid, ictocore, fetch_retry,
        output coretoic_pc_valid, coretoic_pc, ictocore_retry, fetch_valid, fetch_pc, fetch_data,
        output stat_issued, stat_dropped, stat_stall
    );
    modport slave (
        output redirect_valid, redirect_pc, coretoic_pc_retry, ictocore_valid, ictocore, fetch_retry,
        input  coretoic_pc_valid, coretoic_pc, ictocore_retry, fetch_valid, fetch_pc, fetch_data,
        input  stat_issued, stat_dropped, stat_stall
    );
`else
    modport master (
        input  redirect_valid, redirect_pc, coretoic_pc_retry, ictocore_valid, ictocore, fetch_retry,
        output coretoic_pc_valid, coretoic_pc, ictocore_retry, fetch_valid, fetch_pc, fetch_data
    );
    modport slave (
        output redirect_valid, redirect_pc, coretoic_pc_retry, ictocore_valid, ictocore, fetch_retry,
        input  coretoic_pc_valid, coretoic_pc, ictocore_retry, fetch_valid, fetch_pc, fetch_data
    );
`endif
endinterface

// File: rtl/ic_fetch_fifo.sv
// Synchronous FIFO with flush; head entry is readable the cycle after its push.
module ic_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ic_fetch_ctrl.sv
// Fetch engine: issues aligned sequential PCs under a credit limit, pairs responses
// with their PCs for decode, and drops stale responses after a redirect (FETCH_STATS_EN adds counters).
module ic_fetch_ctrl
    import ic_fetch_ctrl_pkg::*;
#(
    parameter int              PC_W        = IC_PC_W,
    parameter int              DATA_W      = IC_DATA_W,
    parameter int              FETCH_BYTES = IC_FETCH_BYTES,
    parameter int              MAX_OUTS    = IC_MAX_OUTS,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic             clk,
    input  logic             reset,
    ic_fetch_ctrl_if.master  ic_if
);
    localparam int              CW         = $clog2(MAX_OUTS + 1);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(FETCH_BYTES - 1);
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(FETCH_BYTES);
    localparam logic [CW:0]     CREDITS    = (CW + 1)'(MAX_OUTS);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    next_pc_q, next_pc_d;
    logic [CW-1:0]      drop_q, drop_d;
    logic [CW-1:0]      inflight, buf_count;
    logic               pcq_empty, pcq_full, buf_empty, buf_full;
    logic [PC_W-1:0]    pcq_head;
    logic [PC_W+DATA_W-1:0] buf_head;
    logic               issue_valid, accept, resp, discard, buf_push, buf_pop;

    // The pc_queue occupancy is the in-flight count; its head pairs with the next response.
    ic_fetch_fifo #(.DEPTH(MAX_OUTS), .WIDTH(PC_W)) u_pc_queue (
        .clk(clk), .reset(reset), .push_i(accept), .wdata_i(next_pc_q), .pop_i(resp),
        .flush_i(1'b0), .rdata_o(pcq_head), .count_o(inflight), .empty_o(pcq_empty), .full_o(pcq_full)
    );

    ic_fetch_fifo #(.DEPTH(MAX_OUTS), .WIDTH(PC_W + DATA_W)) u_out_buf (
        .clk(clk), .reset(reset), .push_i(buf_push), .wdata_i({pcq_head, ic_if.ictocore}),
        .pop_i(buf_pop), .flush_i(ic_if.redirect_valid), .rdata_o(buf_head), .count_o(buf_count),
        .empty_o(buf_empty), .full_o(buf_full)
    );

    // Buffered blocks hold credits too, so the output buffer can never overflow.
    assign issue_valid = !reset && (({1'b0, inflight} + {1'b0, buf_count}) < CREDITS);
    assign accept      = issue_valid && !ic_if.coretoic_pc_retry;
    assign resp        = ic_if.ictocore_valid;
    assign discard     = resp && ((state_q == ST_DRAIN) || ic_if.redirect_valid);
    assign buf_push    = resp && !discard;
    assign buf_pop     = !buf_empty && !ic_if.fetch_retry;

    always_comb begin
        drop_d    = drop_q;
        next_pc_d = next_pc_q;
        if (resp && (state_q == ST_DRAIN)) drop_d = drop_q - CW'(1);
        if (accept) next_pc_d = next_pc_q + PC_STEP;
        // Everything outstanding at the end of a redirect cycle is stale.
        if (ic_if.redirect_valid) begin
            drop_d    = inflight + CW'(accept) - CW'(resp);
            next_pc_d = ic_if.redirect_pc & ALIGN_MASK;
        end
        state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            drop_q    <= '0;
            next_pc_q <= RESET_PC & ALIGN_MASK;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            next_pc_q <= next_pc_d;
        end
    end

    assign ic_if.coretoic_pc_valid = issue_valid;
    assign ic_if.coretoic_pc       = next_pc_q;
    assign ic_if.ictocore_retry    = 1'b0;
    assign ic_if.fetch_valid       = !buf_empty;
    assign {ic_if.fetch_pc, ic_if.fetch_data} = buf_empty ? '0 : buf_head;

`ifdef FETCH_STATS_EN
    logic [31:0] stat_issued_q, stat_dropped_q, stat_stall_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued_q  <= '0;
            stat_dropped_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            if (accept)                                 stat_issued_q  <= sat_inc(stat_issued_q);
            if (discard)                                stat_dropped_q <= sat_inc(stat_dropped_q);
            if (issue_valid && ic_if.coretoic_pc_retry) stat_stall_q   <= sat_inc(stat_stall_q);
        end
    end

    assign ic_if.stat_issued  = stat_issued_q;
    assign ic_if.stat_dropped = stat_dropped_q;
    assign ic_if.stat_stall   = stat_stall_q;
`endif

`ifndef SYNTHESIS
    a_drop_le_inflight: assert property (@(posedge clk) disable iff (reset) drop_q <= inflight);
    a_inflight_le_max:  assert property (@(posedge clk) disable iff (reset) inflight <= CW'(MAX_OUTS));
    a_resp_needs_req:   assert property (@(posedge clk) disable iff (reset) resp |-> !pcq_empty);
    a_pcq_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(accept && !resp && pcq_full));
    a_buf_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(buf_push && !buf_pop && buf_full));
`endif

endmodule

// File: tb/tb_ic_fetch_ctrl.sv
// Directed per-cycle vector table for ic_fetch_ctrl plus hand-written stall/credit sequences.
module tb_ic_fetch_ctrl;
    import ic_fetch_ctrl_pkg::*;

    localparam int PW = 50;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ic_fetch_ctrl_if #(.PC_W(PW), .DATA_W(DW)) bus ();

    ic_fetch_ctrl #(
        .PC_W(PW), .DATA_W(DW), .FETCH_BYTES(IC_FETCH_BYTES), .MAX_OUTS(IC_MAX_OUTS), .RESET_PC('0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ic_if(bus.master)
    );

    typedef struct {
        logic          rst;
        logic          rv;
        logic [PW-1:0] rpc;
        logic          pr;
        logic          iv;
        logic [DW-1:0] idata;
        logic          fr;
        logic          ecv;
        logic [PW-1:0] ecpc;
        logic          efv;
        logic [PW-1:0] efpc;
        logic [DW-1:0] efdata;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [DW-1:0] dat(input int k);
        return {4{32'hCAFE_0000 + 32'(k)}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic row(input logic rv, input logic [PW-1:0] rpc, input logic pr, input logic iv,
                       input logic [DW-1:0] idata, input logic fr, input logic ecv,
                       input logic [PW-1:0] ecpc, input logic efv, input logic [PW-1:0] efpc,
                       input logic [DW-1:0] efdata);
        vec_t v;
        v.rst = 1'b0; v.rv = rv; v.rpc = rpc; v.pr = pr; v.iv = iv; v.idata = idata; v.fr = fr;
        v.ecv = ecv; v.ecpc = ecpc; v.efv = efv; v.efpc = efpc; v.efdata = efdata;
        tbl.push_back(v);
    endtask

    task automatic rst_rows();
        vec_t v;
        v.rst = 1'b1; v.rv = 1'b0; v.rpc = '0; v.pr = 1'b0; v.iv = 1'b0; v.idata = '0; v.fr = 1'b0;
        v.ecv = 1'b0; v.ecpc = '0; v.efv = 1'b0; v.efpc = '0; v.efdata = '0;
        tbl.push_back(v);
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic rv, input logic [PW-1:0] rpc, input logic pr,
                         input logic iv, input logic [DW-1:0] idata, input logic fr);
        reset                 = rst;
        bus.redirect_valid    = rv;
        bus.redirect_pc       = rpc;
        bus.coretoic_pc_retry = pr;
        bus.ictocore_valid    = iv;
        bus.ictocore          = idata;
        bus.fetch_retry       = fr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic prev_rst;
        int   acc;

        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        next_cycle();

        // Reset, then sequential fetch with a 2-cycle icache and a free decode.
        rst_rows();
        row(0, 0, 0, 0, 0,        0, 1, 'h00, 0, 0,    0);
        row(0, 0, 0, 0, 0,        0, 1, 'h10, 0, 0,    0);
        row(0, 0, 0, 1, dat(0),   0, 1, 'h20, 0, 0,    0);
        row(0, 0, 0, 1, dat(1),   0, 1, 'h30, 1, 'h00, dat(0));
        row(0, 0, 1, 1, dat(2),   0, 1, 'h40, 1, 'h10, dat(1));
        row(0, 0, 1, 1, dat(3),   0, 1, 'h40, 1, 'h20, dat(2));
        row(0, 0, 1, 0, 0,        0, 1, 'h40, 1, 'h30, dat(3));
        row(0, 0, 1, 0, 0,        0, 1, 'h40, 0, 0,    0);
        // Silent icache: four credits, then one response frees exactly one issue.
        rst_rows();
        row(0, 0, 0, 0, 0,        0, 1, 'h00, 0, 0,    0);
        row(0, 0, 0, 0, 0,        0, 1, 'h10, 0, 0,    0);
        row(0, 0, 0, 0, 0,        0, 1, 'h20, 0, 0,    0);
        row(0, 0, 0, 0, 0,        0, 1, 'h30, 0, 0,    0);
        row(0, 0, 0, 0, 0,        0, 0, 0,    0, 0,    0);
        row(0, 0, 0, 0, 0,        0, 0, 0,    0, 0,    0);
        row(0, 0, 0, 1, dat(4),   0, 0, 0,    0, 0,    0);
        row(0, 0, 0, 0, 0,        0, 0, 0,    1, 'h00, dat(4));
        row(0, 0, 0, 0, 0,        0, 1, 'h40, 0, 0,    0);
        row(0, 0, 0, 0, 0,        0, 0, 0,    0, 0,    0);
        row(0, 0, 0, 0, 0,        0, 0, 0,    0, 0,    0);
        // Three in flight, redirect to 0x1234 while the icache retries.
        rst_rows();
        row(0, 0,      0, 0, 0,         0, 1, 'h00,   0, 0,      0);
        row(0, 0,      0, 0, 0,         0, 1, 'h10,   0, 0,      0);
        row(0, 0,      0, 0, 0,         0, 1, 'h20,   0, 0,      0);
        row(1, 'h1234, 1, 0, 0,         0, 1, 'h30,   0, 0,      0);
        row(0, 0,      0, 1, dat('h90), 0, 1, 'h1230, 0, 0,      0);
        row(0, 0,      0, 1, dat('h91), 0, 1, 'h1240, 0, 0,      0);
        row(0, 0,      1, 1, dat('h92), 0, 1, 'h1250, 0, 0,      0);
        row(0, 0,      1, 1, dat(5),    0, 1, 'h1250, 0, 0,      0);
        row(0, 0,      1, 1, dat(6),    0, 1, 'h1250, 1, 'h1230, dat(5));
        row(0, 0,      1, 0, 0,         0, 1, 'h1250, 1, 'h1240, dat(6));
        row(0, 0,      1, 0, 0,         0, 1, 'h1250, 0, 0,      0);
        // Redirect, response and accept in one cycle with two in flight.
        rst_rows();
        row(0, 0,     0, 0, 0,         0, 1, 'h00,  0, 0,     0);
        row(0, 0,     0, 0, 0,         0, 1, 'h10,  0, 0,     0);
        row(1, 'h500, 0, 1, dat('h93), 0, 1, 'h20,  0, 0,     0);
        row(0, 0,     1, 1, dat('h94), 0, 1, 'h500, 0, 0,     0);
        row(0, 0,     1, 1, dat('h95), 0, 1, 'h500, 0, 0,     0);
        row(0, 0,     0, 0, 0,         0, 1, 'h500, 0, 0,     0);
        row(0, 0,     1, 0, 0,         0, 1, 'h510, 0, 0,     0);
        row(0, 0,     1, 1, dat(7),    0, 1, 'h510, 0, 0,     0);
        row(0, 0,     1, 0, 0,         0, 1, 'h510, 1, 'h500, dat(7));
        row(0, 0,     1, 0, 0,         0, 1, 'h510, 0, 0,     0);
        // Redirect flushes a block that decode is holding off.
        rst_rows();
        row(0, 0,      0, 0, 0,      0, 1, 'h00,   0, 0,      0);
        row(0, 0,      1, 1, dat(8), 1, 1, 'h10,   0, 0,      0);
        row(1, 'h2000, 1, 0, 0,      1, 1, 'h10,   1, 'h00,   dat(8));
        row(0, 0,      1, 0, 0,      0, 1, 'h2000, 0, 0,      0);
        row(0, 0,      0, 0, 0,      0, 1, 'h2000, 0, 0,      0);
        row(0, 0,      1, 1, dat(9), 0, 1, 'h2010, 0, 0,      0);
        row(0, 0,      1, 0, 0,      0, 1, 'h2010, 1, 'h2000, dat(9));
        // Top-of-range PC wraps to zero; redirect target low bits are masked.
        rst_rows();
        row(1, 50'h3_FFFF_FFFF_FFF5, 1, 0, 0,       0, 1, 'h0,                 0, 0,                   0);
        row(0, 0,                    0, 0, 0,       0, 1, 50'h3_FFFF_FFFF_FFF0, 0, 0,                   0);
        row(0, 0,                    1, 0, 0,       0, 1, 'h0,                 0, 0,                   0);
        row(0, 0,                    1, 1, dat(10), 0, 1, 'h0,                 0, 0,                   0);
        row(0, 0,                    1, 0, 0,       0, 1, 'h0,                 1, 50'h3_FFFF_FFFF_FFF0, dat(10));

        prev_rst = 1'b1;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].pr, tbl[i].iv, tbl[i].idata, tbl[i].fr);
            #4;
            chk($sformatf("row%0d cv", i), DW'(bus.coretoic_pc_valid), DW'(tbl[i].ecv));
            if (tbl[i].rst && prev_rst) begin
                chk($sformatf("row%0d rst_fv", i), DW'(bus.fetch_valid), '0);
                chk($sformatf("row%0d rst_iretry", i), DW'(bus.ictocore_retry), '0);
                chk($sformatf("row%0d rst_cpc", i), DW'(bus.coretoic_pc), '0);
                chk($sformatf("row%0d rst_fpc", i), DW'(bus.fetch_pc), '0);
                chk($sformatf("row%0d rst_fdata", i), bus.fetch_data, '0);
            end else if (!tbl[i].rst) begin
                chk($sformatf("row%0d iretry", i), DW'(bus.ictocore_retry), '0);
                if (tbl[i].ecv) chk($sformatf("row%0d cpc", i), DW'(bus.coretoic_pc), DW'(tbl[i].ecpc));
                chk($sformatf("row%0d fv", i), DW'(bus.fetch_valid), DW'(tbl[i].efv));
                if (tbl[i].efv) begin
                    chk($sformatf("row%0d fpc", i), DW'(bus.fetch_pc), DW'(tbl[i].efpc));
                    chk($sformatf("row%0d fdata", i), bus.fetch_data, tbl[i].efdata);
                end
            end
            prev_rst = tbl[i].rst;
            next_cycle();
        end

        // Five cycles of icache back-pressure hold the request, then credits refill.
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        next_cycle();
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
            #4;
            chk($sformatf("stall%0d cv", k), DW'(bus.coretoic_pc_valid), DW'(1));
            chk($sformatf("stall%0d cpc", k), DW'(bus.coretoic_pc), '0);
            next_cycle();
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        #4;
        chk("stall_release cv", DW'(bus.coretoic_pc_valid), DW'(1));
        chk("stall_release cpc", DW'(bus.coretoic_pc), '0);
        next_cycle();
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
            #4;
            if (bus.coretoic_pc_valid) acc++;
            next_cycle();
        end
        chk("credit_refill accepts", DW'(acc), DW'(3));
        #4;
        chk("credit_exhausted cv", DW'(bus.coretoic_pc_valid), '0);
`ifdef FETCH_STATS_EN
        chk("stat_stall", DW'(bus.stat_stall), DW'(5));
        chk("stat_issued", DW'(bus.stat_issued), DW'(4));
        chk("stat_dropped", DW'(bus.stat_dropped), '0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
